// File: rtl/frame_sequencer_pkg.sv
// smash_pkg: shared state encoding, default timing constants and counter
// widths for the frame sequencer and its timer.
package smash_pkg;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t ST_IDLE   = 3'd0;
  localparam seq_state_t ST_SAMPLE = 3'd1;
  localparam seq_state_t ST_PHYS   = 3'd2;
  localparam seq_state_t ST_COLL   = 3'd3;
  localparam seq_state_t ST_VGA    = 3'd4;

  localparam int PHYS_TIMEOUT_DEF = 1023;
  localparam int COLL_WAIT_DEF    = 2;
  localparam int FRAME_COUNT_W    = 32;

  // The shared timer is loaded with (count - 1), so it needs clog2(max) bits.
  function automatic int timerWidth(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Control/status bundle between the game CPU side (master) and the
// frame sequencer (slave).
interface frame_sequencer_if;

  logic frame_tick;
  logic freeze;
  logic phys_done;
  logic clr_status;
  logic ctrl_sample;
  logic phys_step;
  logic coll_latch;
  logic vga_latch;
  logic busy;
  logic overrun;
  logic timeout;
  logic [smash_pkg::FRAME_COUNT_W-1:0] frame_count;

  modport master (
    output frame_tick, freeze, phys_done, clr_status,
    input  ctrl_sample, phys_step, coll_latch, vga_latch,
    input  busy, overrun, timeout, frame_count
  );

  modport slave (
    input  frame_tick, freeze, phys_done, clr_status,
    output ctrl_sample, phys_step, coll_latch, vga_latch,
    output busy, overrun, timeout, frame_count
  );

endinterface

// File: rtl/frame_sequencer_seq_timer.sv
// seq_timer: loadable down-counter with a zero flag; it saturates at zero.
module seq_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadValue_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadValue_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame SAMPLE -> PHYS -> COLL -> VGA strobe sequencer.
// Define FRAME_SEQ_TIMEOUT_EN to compile in the PHYS timeout and sticky timeout flag.
module frame_sequencer
  import smash_pkg::*;
#(
  parameter int PHYS_TIMEOUT = PHYS_TIMEOUT_DEF,
  parameter int COLL_WAIT    = COLL_WAIT_DEF
) (
  input logic              clock,
  input logic              reset,
  frame_sequencer_if.slave bus
);

  localparam int TimerW = timerWidth(PHYS_TIMEOUT, COLL_WAIT);

  seq_state_t               state_q, state_d;
  logic                     physFirst_q, physFirst_d;
  logic                     overrun_q, overrun_d;
  logic [FRAME_COUNT_W-1:0] frameCount_q, frameCount_d;
  logic                     timerLoad, timerEn, timerZero;
  logic [TimerW-1:0]        timerLoadValue;
  logic                     physTimedOut, physExit;

  seq_timer #(.WIDTH(TimerW)) u_timer (
    .clock       (clock),
    .reset       (reset),
    .load_i      (timerLoad),
    .loadValue_i (timerLoadValue),
    .en_i        (timerEn),
    .zero_o      (timerZero)
  );

`ifdef FRAME_SEQ_TIMEOUT_EN
  assign physTimedOut = (state_q == ST_PHYS) && !bus.phys_done && timerZero;
`else
  assign physTimedOut = 1'b0;
`endif
  assign physExit = (state_q == ST_PHYS) && (bus.phys_done || physTimedOut);

  // The one timer is reused: PHYS budget on entry to PHYS, settle wait on entry to COLL.
  always_comb begin
    state_d        = state_q;
    timerLoad      = 1'b0;
    timerLoadValue = '0;
    timerEn        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.frame_tick && !bus.freeze) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        state_d = ST_PHYS;
`ifdef FRAME_SEQ_TIMEOUT_EN
        timerLoad      = 1'b1;
        timerLoadValue = TimerW'(PHYS_TIMEOUT - 1);
`endif
      end
      ST_PHYS: begin
        if (physExit) begin
          state_d        = ST_COLL;
          timerLoad      = 1'b1;
          timerLoadValue = TimerW'(COLL_WAIT - 1);
        end else begin
          timerEn = 1'b1;
        end
      end
      ST_COLL: begin
        if (timerZero) state_d = ST_VGA;
        else           timerEn = 1'b1;
      end
      ST_VGA:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky flags: a set in the same cycle as clr_status takes priority.
  always_comb begin
    physFirst_d  = (state_q == ST_SAMPLE);
    overrun_d    = overrun_q;
    frameCount_d = frameCount_q;
    if (bus.frame_tick && (state_q != ST_IDLE)) overrun_d = 1'b1;
    else if (bus.clr_status)                    overrun_d = 1'b0;
    if (state_q == ST_VGA) frameCount_d = frameCount_q + FRAME_COUNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      physFirst_q  <= 1'b0;
      overrun_q    <= 1'b0;
      frameCount_q <= '0;
    end else begin
      state_q      <= state_d;
      physFirst_q  <= physFirst_d;
      overrun_q    <= overrun_d;
      frameCount_q <= frameCount_d;
    end
  end

`ifdef FRAME_SEQ_TIMEOUT_EN
  logic timeout_q, timeout_d;

  always_comb begin
    timeout_d = timeout_q;
    if (physTimedOut)        timeout_d = 1'b1;
    else if (bus.clr_status) timeout_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) timeout_q <= 1'b0;
    else       timeout_q <= timeout_d;
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.ctrl_sample = (state_q == ST_SAMPLE);
  assign bus.phys_step   = physFirst_q;
  assign bus.coll_latch  = (state_q == ST_COLL) && timerZero;
  assign bus.vga_latch   = (state_q == ST_VGA);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.overrun     = overrun_q;
  assign bus.frame_count = frameCount_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: scoreboard bench; expected strobe events are queued by
// the stimulus from frame-timing rules and popped by an independent monitor.
module tb_frame_sequencer;

  localparam int PT = 8;
  localparam int CW = 2;
`ifdef FRAME_SEQ_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] kind;
  } expEvent_t;

  logic clock;
  logic reset;
  int   cyc;
  int   total;
  int   bad;

  expEvent_t   expQ[$];
  logic [31:0] expCount;
  logic        expOverrun;
  logic        expTimeout;

  frame_sequencer_if bus();

  frame_sequencer #(.PHYS_TIMEOUT(PT), .COLL_WAIT(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void pushEvent(input int c, input logic [3:0] k);
    expEvent_t ev;
    ev.cyc  = c;
    ev.kind = k;
    expQ.push_back(ev);
  endfunction

  // Final value of a sticky flag after one set event and one clear event (-1 = absent).
  function automatic logic stickyAfter(input logic prev, input int setAt, input int clrAt);
    if (setAt < 0 && clrAt < 0) return prev;
    if (setAt < 0) return 1'b0;
    if (clrAt < 0) return 1'b1;
    return (setAt >= clrAt);
  endfunction

  function automatic bit timesOut(input int doneDelay);
    return TimeoutEn && (doneDelay < 0 || doneDelay >= PT);
  endfunction

  // Offset of the last PHYS cycle relative to the accepted tick.
  function automatic int physEnd(input int doneDelay);
    return timesOut(doneDelay) ? 1 + PT : 2 + doneDelay;
  endfunction

  // Offset of the VGA cycle relative to the accepted tick.
  function automatic int vgaOffset(input int doneDelay);
    return physEnd(doneDelay) + CW + 1;
  endfunction

  // One accepted frame; doneDelay = cycles after phys_step before phys_done (-1 = never).
  // overAt/clrAt/freezeAt are cycle offsets from the tick, 0 = unused.
  task automatic applyStimulus(input int doneDelay, input int overAt, input int clrAt, input int freezeAt);
    int t0;
    int k;
    int tEnd;
    int off;
    @(negedge clock);
    t0   = cyc;
    k    = physEnd(doneDelay);
    tEnd = t0 + k + CW + 2;
    pushEvent(t0 + 1, 4'b1000);
    pushEvent(t0 + 2, 4'b0100);
    pushEvent(t0 + k + CW, 4'b0010);
    pushEvent(t0 + k + CW + 1, 4'b0001);
    expCount   = expCount + 32'd1;
    expOverrun = stickyAfter(expOverrun, (overAt > 0) ? overAt : -1, (clrAt > 0) ? clrAt : -1);
    expTimeout = stickyAfter(expTimeout, timesOut(doneDelay) ? k : -1, (clrAt > 0) ? clrAt : -1);
    bus.frame_tick = 1'b1;
    bus.phys_done  = (doneDelay == 0);
    bus.clr_status = 1'b0;
    bus.freeze     = 1'b0;
    while (cyc < tEnd) begin
      @(negedge clock);
      off = cyc - t0;
      bus.frame_tick = (off == overAt);
      bus.clr_status = (off == clrAt);
      bus.phys_done  = (doneDelay >= 0) && (off >= 2 + doneDelay);
      bus.freeze     = (freezeAt > 0) && (off >= freezeAt);
    end
    bus.phys_done = 1'b0;
    bus.freeze    = 1'b0;
    checkOutput("busy after frame", 32'(bus.busy), 32'd0);
    checkOutput("frame_count", bus.frame_count, expCount);
    checkOutput("overrun", 32'(bus.overrun), 32'(expOverrun));
    checkOutput("timeout", 32'(bus.timeout), 32'(expTimeout));
  endtask

  // Monitor: every strobe the DUT raises must match the head of the queue.
  initial begin
    logic [3:0] strobes;
    expEvent_t  ev;
    forever begin
      @(negedge clock);
      strobes = {bus.ctrl_sample, bus.phys_step, bus.coll_latch, bus.vga_latch};
      if (strobes != 4'b0000) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected strobe", 32'(strobes), 32'd0);
        end else begin
          ev = expQ.pop_front();
          checkOutput("strobe cycle", 32'(cyc), 32'(ev.cyc));
          checkOutput("strobe kind", 32'(strobes), 32'(ev.kind));
        end
      end
    end
  end

  initial begin
    int dd;
    int vo;
    int t0;
    total          = 0;
    bad            = 0;
    expCount       = 32'd0;
    expOverrun     = 1'b0;
    expTimeout     = 1'b0;
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.freeze     = 1'b0;
    bus.phys_done  = 1'b0;
    bus.clr_status = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset overrun", 32'(bus.overrun), 32'd0);
    checkOutput("reset timeout", 32'(bus.timeout), 32'd0);
    checkOutput("reset frame_count", bus.frame_count, 32'd0);
    checkOutput("reset strobes", 32'({bus.ctrl_sample, bus.phys_step, bus.coll_latch, bus.vga_latch}), 32'd0);
    reset = 1'b0;

    // Minimum-latency frame, then a slow physics step.
    applyStimulus(0, 0, 0, 0);
    applyStimulus(10, 0, 0, 0);

    // Overrun in cycle 3, then clear; then set and clear in the same cycle.
    applyStimulus(3, 3, 0, 0);
    applyStimulus(0, 0, 2, 0);
    applyStimulus(1, 4, 4, 0);
    applyStimulus(0, vgaOffset(0), 0, 0);
    applyStimulus(0, 0, 1, 0);

    // Frozen ticks must be discarded without overrun.
    @(negedge clock);
    bus.freeze = 1'b1;
    repeat (3) begin
      @(negedge clock);
      bus.frame_tick = 1'b1;
      @(negedge clock);
      bus.frame_tick = 1'b0;
    end
    @(negedge clock);
    bus.freeze = 1'b0;
    checkOutput("frozen frame_count", bus.frame_count, expCount);
    checkOutput("frozen overrun", 32'(bus.overrun), 32'd0);
    checkOutput("frozen busy", 32'(bus.busy), 32'd0);

    // Freeze raised while in PHYS must not abort the frame.
    applyStimulus(4, 0, 0, 3);

`ifdef FRAME_SEQ_TIMEOUT_EN
    applyStimulus(-1, 0, 0, 0);
    applyStimulus(0, 0, 3, 0);
    applyStimulus(PT - 1, 0, 0, 0);
`endif

    // Reset asserted in the first COLL cycle, with overrun already set.
    @(negedge clock);
    t0 = cyc;
    bus.frame_tick = 1'b1;
    bus.phys_done  = 1'b1;
    pushEvent(t0 + 1, 4'b1000);
    pushEvent(t0 + 2, 4'b0100);
    @(negedge clock);
    @(negedge clock);
    bus.frame_tick = 1'b0;
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    checkOutput("mid-reset busy", 32'(bus.busy), 32'd0);
    checkOutput("mid-reset overrun", 32'(bus.overrun), 32'd0);
    checkOutput("mid-reset timeout", 32'(bus.timeout), 32'd0);
    checkOutput("mid-reset frame_count", bus.frame_count, 32'd0);
    checkOutput("mid-reset strobes", 32'({bus.ctrl_sample, bus.phys_step, bus.coll_latch, bus.vga_latch}), 32'd0);
    @(negedge clock);
    reset         = 1'b0;
    bus.phys_done = 1'b0;
    expCount      = 32'd0;
    expOverrun    = 1'b0;
    expTimeout    = 1'b0;
    applyStimulus(0, 0, 0, 0);

    // Counter wrap from all-ones.
    @(negedge clock);
    force dut.frameCount_q = 32'hFFFF_FFFF;
    @(negedge clock);
    release dut.frameCount_q;
    expCount = 32'hFFFF_FFFF;
    applyStimulus(0, 0, 0, 0);

    // Randomized frames with random overrun, clear and freeze events.
    for (int i = 0; i < 24; i++) begin
      dd = $urandom_range(0, 12);
      vo = vgaOffset(dd);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      applyStimulus(dd,
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, vo) : 0,
                    ($urandom_range(0, 2) == 2) ? $urandom_range(1, vo) : 0,
                    ($urandom_range(0, 3) == 3) ? $urandom_range(1, vo) : 0);
    end

    repeat (4) @(negedge clock);
    checkOutput("leftover expected strobes", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter PHYS_TIMEOUT, default 1023; maximum cycles spent waiting for phys_done in PHYS (range 1..65535).
REQ-002 Parameter COLL_WAIT, default 2; cycles spent in COLL so collision outputs settle (range 1..15).
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 frame_tick  input  1  one-cycle frame-start pulse (VGA vsync domain, already synchronised).
REQ-006 freeze  input  1  level; while high, new frames are not started.
REQ-007 phys_done  input  1  physics step complete; level or pulse.
REQ-008 clr_status  input  1  one-cycle pulse; clears sticky overrun and timeout flags.
REQ-009 ctrl_sample  output  1  one-cycle strobe; latch both game-controller words.
REQ-010 phys_step  output  1  one-cycle strobe; advance both physics coprocessors one step.
REQ-011 coll_latch  output  1  one-cycle strobe; latch collision results into physics wall inputs.
REQ-012 vga_latch  output  1  one-cycle strobe; latch positions into the VGA coprocessors.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 overrun  output  1  sticky; frame_tick arrived while busy.
REQ-015 timeout  output  1  sticky; PHYS exited on timeout.
REQ-016 frame_count  output  32  completed frames, for MMIO readback.

Function
REQ-017 The FSM SHALL have exactly five states: IDLE, SAMPLE, PHYS, COLL, VGA; all strobes are Moore outputs decoded from registered state.
REQ-018 IDLE -> SAMPLE when frame_tick=1 and freeze=0; otherwise the FSM stays in IDLE and the tick is discarded silently.
REQ-019 SAMPLE SHALL last one cycle with ctrl_sample=1, then go to PHYS.
REQ-020 phys_step SHALL be 1 only in the first PHYS cycle.
REQ-021 phys_done SHALL be sampled in every PHYS cycle including the first; PHYS -> COLL on phys_done=1.
REQ-022 PHYS -> COLL SHALL also occur when the PHYS cycle counter reaches PHYS_TIMEOUT; timeout is set that cycle.
REQ-023 COLL SHALL last exactly COLL_WAIT cycles, with coll_latch=1 in its last cycle only, then go to VGA.
REQ-024 VGA SHALL last one cycle with vga_latch=1; frame_count increments by 1 that cycle; next state is IDLE.
REQ-025 Minimum latency SHALL be: tick at cycle 0 -> SAMPLE 1, PHYS 2 (phys_done already high), COLL 3-4, VGA 5, IDLE 6 (COLL_WAIT=2).
REQ-026 frame_tick while busy=1 SHALL set overrun and SHALL NOT queue a frame.
REQ-027 frame_tick in the VGA cycle SHALL count as busy (overrun set, no new frame).
REQ-028 If clr_status and a flag-setting event occur in the same cycle, the set SHALL win.
REQ-029 freeze rising mid-frame SHALL NOT abort the frame; it gates only the IDLE -> SAMPLE transition.
REQ-030 frame_count SHALL wrap from 0xFFFFFFFF to 0 with no flag.

Reset
REQ-031 reset=1 SHALL force state to IDLE, clear all strobes, busy, overrun, timeout and internal counters, and set frame_count to 0 asynchronously, including mid-frame.
REQ-032 After reset deasserts, the first accepted frame_tick SHALL be the first one seen in IDLE.

Configuration
REQ-033 Macro FRAME_SEQ_TIMEOUT_EN, when defined, SHALL compile in the PHYS timeout counter and REQ-022 behaviour.
REQ-034 Without FRAME_SEQ_TIMEOUT_EN, PHYS SHALL wait indefinitely for phys_done, timeout SHALL be constant 0, and PHYS_TIMEOUT SHALL be unused.

Structure
REQ-035 Shared package smash_pkg SHALL hold the state encoding type (3-bit), the default constants for PHYS_TIMEOUT and COLL_WAIT, and the frame_count width.
REQ-036 One sub-module, seq_timer (loadable down-counter with a zero flag), SHALL serve both the COLL wait and the PHYS timeout counts.

Verification
REQ-037 reset, 1 tick, phys_done held 1 -> strobes at cycles 1/2/4/5, busy is 0 at cycle 6, frame_count=1.
REQ-038 Tick, phys_done raised 10 cycles after phys_step -> COLL entered the next cycle, timeout=0.
REQ-039 (FRAME_SEQ_TIMEOUT_EN, PHYS_TIMEOUT=8) tick, phys_done never asserted -> COLL after 8 PHYS cycles, timeout=1, vga_latch still issued.
REQ-040 Second tick in cycle 3 of a frame -> overrun=1, only one frame counted; clr_status -> overrun=0.
REQ-041 freeze=1 with 3 ticks -> no strobes, frame_count unchanged; freeze raised in PHYS -> frame completes.
REQ-042 reset pulsed during COLL -> all outputs 0 immediately; frame_count preloaded 0xFFFFFFFF by forcing then 1 frame -> 0.
